// File: rtl/polybius_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : polybius_pkg                                               |
// | Description : Shared types, constants and helpers for the modified       |
// |               Polybius cipher (encryptor and streaming decryptor).       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package polybius_pkg;

   // Decoder state: expecting the row digit or the column digit of a pair.
   typedef enum logic [0:0] {
      ROW = 1'b0,
      COL = 1'b1
   } state_t;

   localparam logic [7:0] ASCII_ONE    = 8'h31;
   localparam logic [7:0] DEFAULT_BASE = 8'h2A;

   // A digit is legal when it lies in '1'..('0'+grid).
   function automatic logic digit_ok(input logic [7:0] d, input int grid);
      logic [7:0] hi;
      hi = 8'h30 + 8'(grid);
      return (d >= ASCII_ONE) && (d <= hi);
   endfunction

   // Character stored in cell (r, c), 0-based, row-major from base.
   // The elaboration check on the parameters guarantees no 8-bit wrap.
   function automatic logic [7:0] cell_char(input logic [7:0] base,
                                            input logic [3:0] r,
                                            input logic [3:0] c,
                                            input int         grid);
      logic [7:0] g8;
      g8 = 8'(grid);
      return base + ({4'd0, r} * g8) + {4'd0, c};
   endfunction

endpackage
`default_nettype wire

// File: rtl/polybius_modified_decrypt_stream_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : polybius_modified_decrypt_stream_if                        |
// | Description : Byte input stream and character output stream of the      |
// |               Polybius decryptor, both valid/ready handshaked.           |
// |   in_data/in_valid/in_ready     : ASCII digit byte stream (to decoder)   |
// |   out_char/out_err/out_valid/out_ready : decrypted char stream (to sink) |
// |   slave  modport : decoder side;  master modport : source/sink side      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface polybius_modified_decrypt_stream_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_char;
   logic       out_err;
   logic       out_valid;
   logic       out_ready;

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_char, out_err, out_valid
   );

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_char, out_err, out_valid
   );
endinterface
`default_nettype wire

// File: rtl/polybius_digit_decode.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : polybius_digit_decode                                      |
// | Description : Combinational ASCII digit decode.                          |
// |   in_data [7:0] in  : ASCII byte                                         |
// |   legal         out : byte is a digit '1'..('0'+GRID)                    |
// |   idx     [3:0] out : 0-based grid index (0 when illegal)                |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module polybius_digit_decode
   import polybius_pkg::*;
#(
   parameter int GRID = 7
) (
   input  logic [7:0] in_data,
   output logic       legal,
   output logic [3:0] idx
);

   // For '1'..'9' the low nibble is 1..9, so the index is simply nibble-1.
   always_comb begin
      legal = digit_ok(in_data, GRID);
      idx   = legal ? (in_data[3:0] - 4'd1) : 4'd0;
   end

endmodule
`default_nettype wire

// File: rtl/polybius_modified_decrypt_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : polybius_modified_decrypt_stream                           |
// | Description : Streaming modified-Polybius decryptor. Takes ASCII digit   |
// |               pairs (row, col), one byte per handshake, and emits one    |
// |               character per pair; malformed digits give error beats.     |
// |   clk        in  : rising-edge clock                                     |
// |   rst_n      in  : asynchronous active-low reset                         |
// |   sync_clr   in  : drop any half pair, return to ROW                     |
// |   bus        slave modport : in_* byte stream, out_* char stream        |
// |   char_count out : good characters emitted (saturating)                  |
// |   err_count  out : error beats emitted (saturating)                      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module polybius_modified_decrypt_stream
   import polybius_pkg::*;
#(
   parameter int         GRID      = 7,
   parameter logic [7:0] BASE_CHAR = DEFAULT_BASE,
   parameter int         CNT_W     = 16
) (
   input  logic                                    clk,
   input  logic                                    rst_n,
   input  logic                                    sync_clr,
   polybius_modified_decrypt_stream_if.slave       bus,
   output logic [CNT_W-1:0]                        char_count,
   output logic [CNT_W-1:0]                        err_count
);

   if ((GRID < 1) || (GRID > 9) || ((int'(BASE_CHAR) + GRID * GRID - 1) > 255)) begin : g_param_check
      $error("polybius_modified_decrypt_stream: GRID/BASE_CHAR out of range");
   end

   state_t           state_q, state_d;
   logic [3:0]       row_q, row_d;
   logic             out_valid_q, out_valid_d;
   logic [7:0]       out_char_q, out_char_d;
   logic             out_err_q, out_err_d;
   logic [CNT_W-1:0] char_count_q, char_count_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic       dig_legal;
   logic [3:0] dig_idx;
   logic       out_free;
   logic       in_ready;
   logic       accept;
   logic       load;
   logic       load_err;
   logic [7:0] load_char;
   logic       drain;

   polybius_digit_decode #(
      .GRID (GRID)
   ) u_digit_decode (
      .in_data (bus.in_data),
      .legal   (dig_legal),
      .idx     (dig_idx)
   );

   assign out_free = !out_valid_q || bus.out_ready;
   assign drain    = out_valid_q && bus.out_ready;

   // A legal row digit never touches the output register, so it may be
   // taken even while the output is stalled; only error beats need room.
   always_comb begin
      in_ready = 1'b0;
      if (!sync_clr) begin
         if (state_q == ROW) in_ready = dig_legal || out_free;
         else                in_ready = out_free;
      end
   end

   assign accept = bus.in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      load      = 1'b0;
      load_err  = 1'b0;
      load_char = 8'h00;
      if (sync_clr) begin
         state_d = ROW;
      end else if (accept) begin
         case (state_q)
            ROW: begin
               if (dig_legal) begin
                  row_d   = dig_idx;
                  state_d = COL;
               end else begin
                  load     = 1'b1;
                  load_err = 1'b1;
               end
            end
            COL: begin
               state_d = ROW;
               load    = 1'b1;
               // row_q only ever holds a legal index, so the col digit decides.
               if (dig_legal) load_char = cell_char(BASE_CHAR, row_q, dig_idx, GRID);
               else           load_err  = 1'b1;
            end
            default: state_d = ROW;
         endcase
      end
   end

   always_comb begin
      out_valid_d = out_valid_q;
      out_char_d  = out_char_q;
      out_err_d   = out_err_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_char_d  = load_char;
         out_err_d   = load_err;
      end else if (drain) begin
         out_valid_d = 1'b0;
      end
   end

   always_comb begin
      char_count_d = char_count_q;
      err_count_d  = err_count_q;
      if (drain) begin
         if (out_err_q) begin
            if (err_count_q != '1) err_count_d = err_count_q + CNT_W'(1);
         end else begin
            if (char_count_q != '1) char_count_d = char_count_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ROW;
         row_q        <= 4'd0;
         out_valid_q  <= 1'b0;
         out_char_q   <= 8'h00;
         out_err_q    <= 1'b0;
         char_count_q <= '0;
         err_count_q  <= '0;
      end else begin
         state_q      <= state_d;
         row_q        <= row_d;
         out_valid_q  <= out_valid_d;
         out_char_q   <= out_char_d;
         out_err_q    <= out_err_d;
         char_count_q <= char_count_d;
         err_count_q  <= err_count_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid_q;
   assign bus.out_char  = out_char_q;
   assign bus.out_err   = out_err_q;
   assign char_count    = char_count_q;
   assign err_count     = err_count_q;

endmodule
`default_nettype wire

// File: tb/tb_polybius_modified_decrypt_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_polybius_modified_decrypt_stream                        |
// | Description : Self-checking bench for the Polybius stream decryptor:     |
// |               directed scenarios plus a randomized stream compared with  |
// |               a pair-parsing reference model.                            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_polybius_modified_decrypt_stream;

   localparam int         TB_GRID  = 7;
   localparam logic [7:0] TB_BASE  = 8'h2A;
   localparam int         TB_CNT_W = 16;
   localparam int         BUDGET   = 64;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                sync_clr = 1'b0;
   logic [TB_CNT_W-1:0] char_count;
   logic [TB_CNT_W-1:0] err_count;

   polybius_modified_decrypt_stream_if bus ();

   polybius_modified_decrypt_stream #(
      .GRID      (TB_GRID),
      .BASE_CHAR (TB_BASE),
      .CNT_W     (TB_CNT_W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sync_clr   (sync_clr),
      .bus        (bus),
      .char_count (char_count),
      .err_count  (err_count)
   );

   always #5 clk = ~clk;

   int tests_run    = 0;
   int tests_failed = 0;

   logic [7:0] stim[$];
   logic [8:0] expq[$];
   logic [8:0] got[$];
   int         exp_chars;
   int         exp_errs;
   bit         done;

   // Every beat the sink takes is recorded as {err, char}.
   always @(negedge clk) begin
      if (rst_n && bus.out_valid && bus.out_ready) got.push_back({bus.out_err, bus.out_char});
   end

   // Reference: parse the accepted byte sequence into pairs.
   task automatic build_expected();
      int pend;
      int v;
      pend = -1;
      expq.delete();
      exp_chars = 0;
      exp_errs  = 0;
      foreach (stim[i]) begin
         v = int'(stim[i]) - 48;
         if (pend < 0) begin
            if (v >= 1 && v <= TB_GRID) pend = v - 1;
            else begin expq.push_back({1'b1, 8'h00}); exp_errs++; end
         end else begin
            if (v >= 1 && v <= TB_GRID) begin
               expq.push_back({1'b0, 8'(int'(TB_BASE) + pend * TB_GRID + v - 1)});
               exp_chars++;
            end else begin
               expq.push_back({1'b1, 8'h00});
               exp_errs++;
            end
            pend = -1;
         end
      end
   endtask

   // Entered and left at posedge+1.
   task automatic send_byte(input logic [7:0] b);
      bit ok;
      bit acc;
      ok = 1'b0;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      for (int i = 0; i < BUDGET && !ok; i++) begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         if (acc) ok = 1'b1;
      end
      bus.in_valid = 1'b0;
      bus.in_data  = 8'($urandom);
      if (!ok) begin
         tests_run++;
         tests_failed++;
         $display("FAIL send_timeout: byte %02h never accepted within %0d cycles", b, BUDGET);
      end
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      sync_clr     = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = 8'h00;
      bus.out_ready = 1'b1;
      idle(2);
      rst_n = 1'b1;
      idle(1);
      got.delete();
   endtask

   task automatic check_got(input string name, input logic [8:0] want[$]);
      tests_run++;
      if (got.size() != want.size()) begin
         tests_failed++;
         $display("FAIL %s_count: got %0d beats, want %0d", name, got.size(), want.size());
      end else begin
         foreach (want[i]) begin
            tests_run++;
            if (got[i] !== want[i]) begin
               tests_failed++;
               $display("FAIL %s_beat%0d: got err=%0b char=%02h, want err=%0b char=%02h",
                        name, i, got[i][8], got[i][7:0], want[i][8], want[i][7:0]);
            end
         end
      end
   endtask

   task automatic check_counts(input string name, input int wc, input int we);
      tests_run++;
      if (char_count !== TB_CNT_W'(wc) || err_count !== TB_CNT_W'(we)) begin
         tests_failed++;
         $display("FAIL %s_counters: got char=%0d err=%0d, want char=%0d err=%0d",
                  name, char_count, err_count, wc, we);
      end
   endtask

   task automatic test_reset();
      do_reset();
      @(negedge clk);
      tests_run++;
      if (bus.out_valid !== 1'b0 || bus.out_char !== 8'h00 || bus.out_err !== 1'b0 || bus.in_ready !== 1'b1) begin
         tests_failed++;
         $display("FAIL reset_outputs: got v=%0b c=%02h e=%0b rdy=%0b, want 0 00 0 1",
                  bus.out_valid, bus.out_char, bus.out_err, bus.in_ready);
      end
      check_counts("reset", 0, 0);
      @(posedge clk); #1;
   endtask

   task automatic test_stream();
      do_reset();
      send_str("114777");
      idle(3);
      check_got("stream", '{9'h02A, 9'h045, 9'h05A});
      check_counts("stream", 3, 0);
   endtask

   task automatic test_illegal_row();
      do_reset();
      send_str("812");
      idle(3);
      check_got("bad_row", '{9'h100, 9'h02B});
      check_counts("bad_row", 1, 1);
   endtask

   task automatic test_illegal_col();
      do_reset();
      send_str("4021");
      idle(3);
      check_got("bad_col", '{9'h100, 9'h031});
      check_counts("bad_col", 1, 1);
   endtask

   task automatic test_backpressure();
      do_reset();
      bus.out_ready = 1'b0;
      send_str("113");
      bus.in_data  = "4";
      bus.in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_char !== 8'h2A) begin
            tests_failed++;
            $display("FAIL stall_cycle%0d: got rdy=%0b v=%0b c=%02h, want rdy=0 v=1 c=2a",
                     i, bus.in_ready, bus.out_valid, bus.out_char);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      send_byte("4");
      idle(3);
      check_got("stall", '{9'h02A, 9'h03B});
      check_counts("stall", 2, 0);
   endtask

   task automatic test_sync_clr();
      do_reset();
      send_byte("5");
      bus.in_data  = "6";
      bus.in_valid = 1'b1;
      sync_clr     = 1'b1;
      @(negedge clk);
      tests_run++;
      if (bus.in_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL sync_clr_ready: got in_ready=%0b, want 0", bus.in_ready);
      end
      @(posedge clk); #1;
      sync_clr     = 1'b0;
      bus.in_valid = 1'b0;
      send_str("66");
      idle(3);
      stim = '{8'h36, 8'h36};
      build_expected();
      check_got("sync_clr", expq);
   endtask

   task automatic test_reset_mid();
      do_reset();
      send_str("11");
      idle(2);
      bus.out_ready = 1'b0;
      send_str("112");
      rst_n = 1'b0;
      #1;
      tests_run++;
      if (bus.out_valid !== 1'b0 || char_count !== '0 || err_count !== '0) begin
         tests_failed++;
         $display("FAIL async_reset: got v=%0b char=%0d err=%0d, want 0 0 0",
                  bus.out_valid, char_count, err_count);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      idle(1);
      got.delete();
      send_str("22");
      idle(3);
      check_got("after_reset", '{9'h032});
      check_counts("after_reset", 1, 0);
   endtask

   task automatic test_random();
      int r;
      do_reset();
      stim.delete();
      for (int i = 0; i < 400; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 7)       stim.push_back(8'(8'h31 + $urandom_range(0, TB_GRID - 1)));
         else if (r == 7) stim.push_back(8'h30);
         else if (r == 8) stim.push_back(8'(8'h38 + $urandom_range(0, 1)));
         else             stim.push_back(8'($urandom));
      end
      build_expected();
      done = 1'b0;
      fork
         begin
            foreach (stim[i]) begin
               idle(int'($urandom_range(0, 1)));
               send_byte(stim[i]);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               if (!done) bus.out_ready = ($urandom_range(0, 3) != 0);
            end
         end
      join
      bus.out_ready = 1'b1;
      idle(4);
      check_got("random", expq);
      check_counts("random", exp_chars, exp_errs);
   endtask

   initial begin
      bus.in_data   = 8'h00;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      test_reset();
      test_stream();
      test_illegal_row();
      test_illegal_col();
      test_backpressure();
      test_sync_clr();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
`default_nettype wire
